// File: rtl/pl_shift_reg_scan.sv
// Shift/rotate register with a registered ones count, shown on a
// two-digit multiplexed active-low seven-segment display.
module pl_shift_reg_scan #(
  parameter int WIDTH    = 8,
  parameter int SCAN_DIV = 1000,
  localparam int CW      = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [1:0]       mode,
  input  logic             ser_in,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] q,
  output logic [CW-1:0]    ones,
  output logic [6:0]       seg,
  output logic [1:0]       an
);

  localparam int SW = $clog2(SCAN_DIV);

  logic [WIDTH-1:0] r_q;
  logic [CW-1:0]    r_ones;
  logic [SW-1:0]    r_cnt;
  logic             r_sel;
  logic [6:0]       r_seg;
  logic [1:0]       r_an;

  logic [WIDTH-1:0] w_q_next;
  logic [CW-1:0]    w_pop;
  logic [7:0]       w_ones8;
  logic [3:0]       w_units;
  logic [3:0]       w_tens;
  logic [3:0]       w_digit;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 7'b1000000;
      4'd1:    seg_of = 7'b1111001;
      4'd2:    seg_of = 7'b0100100;
      4'd3:    seg_of = 7'b0110000;
      4'd4:    seg_of = 7'b0011001;
      4'd5:    seg_of = 7'b0010010;
      4'd6:    seg_of = 7'b0000010;
      4'd7:    seg_of = 7'b1111000;
      4'd8:    seg_of = 7'b0000000;
      4'd9:    seg_of = 7'b0010000;
      default: seg_of = 7'b1111111;
    endcase
  endfunction

  always_comb begin
    w_q_next = r_q;
    if (load) begin
      w_q_next = data;
    end else begin
      case (mode)
        2'b01:   w_q_next = {r_q[WIDTH-2:0], ser_in};
        2'b10:   w_q_next = {ser_in, r_q[WIDTH-1:1]};
        2'b11:   w_q_next = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
        default: w_q_next = r_q;
      endcase
    end
  end

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_pop = w_pop + CW'(r_q[i]);
    end
  end

  // Tens digit code 4'hF falls to the blank default of seg_of.
  always_comb begin
    w_ones8 = 8'(r_ones);
    w_units = 4'(w_ones8 % 8'd10);
    w_tens  = 4'(w_ones8 / 8'd10);
    w_digit = w_units;
    if (r_sel) begin
      w_digit = (w_ones8 < 8'd10) ? 4'hF : w_tens;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q    <= '0;
      r_ones <= '0;
    end else if (en) begin
      r_q    <= w_q_next;
      r_ones <= w_pop;
    end
  end

  // The scan runs regardless of en so the display never stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      r_sel <= 1'b0;
      r_seg <= 7'b1000000;
      r_an  <= 2'b10;
    end else begin
      if (r_cnt == SW'(SCAN_DIV - 1)) begin
        r_cnt <= '0;
        r_sel <= ~r_sel;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      r_seg <= seg_of(w_digit);
      r_an  <= r_sel ? 2'b01 : 2'b10;
    end
  end

  assign q    = r_q;
  assign ones = r_ones;
  assign seg  = r_seg;
  assign an   = r_an;

endmodule

// File: tb/tb_pl_shift_reg_scan.sv
// Self-checking bench: an 8-bit and a 16-bit instance compared every cycle
// against an arithmetic reference model, plus hand-computed literal checks.
module tb_pl_shift_reg_scan;

  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        a_en = 1'b0, a_load = 1'b0, a_ser = 1'b0;
  logic [1:0]  a_mode = 2'b00;
  logic [7:0]  a_data = 8'h00;
  logic [7:0]  a_q;
  logic [3:0]  a_ones;
  logic [6:0]  a_seg;
  logic [1:0]  a_an;

  logic        b_en = 1'b0, b_load = 1'b0, b_ser = 1'b0;
  logic [1:0]  b_mode = 2'b00;
  logic [15:0] b_data = 16'h0000;
  logic [15:0] b_q;
  logic [4:0]  b_ones;
  logic [6:0]  b_seg;
  logic [1:0]  b_an;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pl_shift_reg_scan #(.WIDTH(8), .SCAN_DIV(SD)) dut_a (
    .clk(clk), .rst(rst), .en(a_en), .load(a_load), .mode(a_mode),
    .ser_in(a_ser), .data(a_data), .q(a_q), .ones(a_ones), .seg(a_seg), .an(a_an)
  );

  pl_shift_reg_scan #(.WIDTH(16), .SCAN_DIV(SD)) dut_b (
    .clk(clk), .rst(rst), .en(b_en), .load(b_load), .mode(b_mode),
    .ser_in(b_ser), .data(b_data), .q(b_q), .ones(b_ones), .seg(b_seg), .an(b_an)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] digit_seg(input int d);
    logic [6:0] tab [0:9];
    tab[0] = 7'b1000000; tab[1] = 7'b1111001; tab[2] = 7'b0100100;
    tab[3] = 7'b0110000; tab[4] = 7'b0011001; tab[5] = 7'b0010010;
    tab[6] = 7'b0000010; tab[7] = 7'b1111000; tab[8] = 7'b0000000;
    tab[9] = 7'b0010000;
    return tab[d];
  endfunction

  // Display shown after n edges reflects digit slot and ones as of n-1 edges.
  function automatic logic [1:0] exp_an(input int n);
    int s;
    s = (n == 0) ? 0 : ((n - 1) / SD) % 2;
    return (s == 1) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [6:0] exp_seg(input int n, input int disp_ones);
    int s;
    s = (n == 0) ? 0 : ((n - 1) / SD) % 2;
    if (s == 0) return digit_seg(disp_ones % 10);
    if (disp_ones < 10) return 7'b1111111;
    return digit_seg(disp_ones / 10);
  endfunction

  function automatic logic [15:0] next_q(input logic [15:0] cur, input int w,
                                         input logic ld, input logic [15:0] d,
                                         input logic [1:0] md, input logic si);
    logic [15:0] msk;
    msk = 16'((32'h1 << w) - 1);
    if (ld) return d & msk;
    case (md)
      2'b01:   return ((cur << 1) | 16'(si)) & msk;
      2'b10:   return (cur >> 1) | (16'(si) << (w - 1));
      2'b11:   return ((cur << 1) | (cur >> (w - 1))) & msk;
      default: return cur;
    endcase
  endfunction

  logic [15:0] ma_q, mb_q;
  int          ma_ones, mb_ones, ma_dones, mb_dones, ma_n, mb_n;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ma_q <= '0; ma_ones <= 0; ma_dones <= 0; ma_n <= 0;
      mb_q <= '0; mb_ones <= 0; mb_dones <= 0; mb_n <= 0;
    end else begin
      ma_n <= ma_n + 1;
      mb_n <= mb_n + 1;
      ma_dones <= ma_ones;
      mb_dones <= mb_ones;
      if (a_en) begin
        ma_ones <= $countones(ma_q);
        ma_q    <= next_q(ma_q, 8, a_load, 16'(a_data), a_mode, a_ser);
      end
      if (b_en) begin
        mb_ones <= $countones(mb_q);
        mb_q    <= next_q(mb_q, 16, b_load, b_data, b_mode, b_ser);
      end
    end
  end

  always @(negedge clk) begin
    chk("a_q",    32'(a_q),    32'(ma_q[7:0]));
    chk("a_ones", 32'(a_ones), 32'(ma_ones));
    chk("a_an",   32'(a_an),   32'(exp_an(ma_n)));
    chk("a_seg",  32'(a_seg),  32'(exp_seg(ma_n, ma_dones)));
    chk("b_q",    32'(b_q),    32'(mb_q));
    chk("b_ones", 32'(b_ones), 32'(mb_ones));
    chk("b_an",   32'(b_an),   32'(exp_an(mb_n)));
    chk("b_seg",  32'(b_seg),  32'(exp_seg(mb_n, mb_dones)));
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [1:0] prev_an;
    int         changes;
    step(2);
    chk("rst_q",   32'(a_q),   32'h0);
    chk("rst_an",  32'(a_an),  32'h2);
    chk("rst_seg", 32'(a_seg), 32'b1000000);
    rst = 1'b1;

    a_en = 1'b1; a_load = 1'b1; a_data = 8'hB5;
    b_en = 1'b1; b_load = 1'b1; b_data = 16'hFFFF;
    step(1);
    chk("load_q", 32'(a_q), 32'hB5);
    a_load = 1'b0; b_load = 1'b0;
    step(1);
    chk("load_ones", 32'(a_ones), 32'd5);
    step(1);
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (a_an == 2'b10) chk("b5_units", 32'(a_seg), 32'b0010010);
      else begin
        chk("b5_an", 32'(a_an), 32'b01);
        chk("b5_tens", 32'(a_seg), 32'b1111111);
      end
    end

    chk("w16_ones", 32'(b_ones), 32'd16);
    prev_an = b_an;
    changes = 0;
    for (int i = 0; i < 16; i++) begin
      step(1);
      if (b_an != prev_an) changes++;
      prev_an = b_an;
      if (b_an == 2'b10) chk("w16_units", 32'(b_seg), 32'b0000010);
      else chk("w16_tens", 32'(b_seg), 32'b1111001);
    end
    chk("w16_an_toggles", 32'(changes), 32'd4);

    a_load = 1'b1; a_data = 8'h01;
    step(1);
    a_load = 1'b0; a_mode = 2'b11; a_ser = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      logic [7:0] e;
      step(1);
      e = (i == 8) ? 8'h01 : 8'(1 << i);
      chk("ring_q", 32'(a_q), 32'(e));
      chk("ring_ones", 32'(a_ones), 32'd1);
    end

    a_mode = 2'b00; a_load = 1'b1; a_data = 8'h00;
    step(1);
    a_load = 1'b0; a_mode = 2'b01; a_ser = 1'b1;
    step(3);
    chk("shl_q", 32'(a_q), 32'h07);
    a_mode = 2'b00;
    step(1);
    chk("shl_ones", 32'(a_ones), 32'd3);
    a_mode = 2'b10; a_ser = 1'b0;
    step(1);
    chk("shr_q", 32'(a_q), 32'h03);

    a_mode = 2'b00; a_en = 1'b0; a_load = 1'b1; a_data = 8'hFF;
    step(2);
    chk("en0_q", 32'(a_q), 32'h03);
    chk("en0_ones", 32'(a_ones), 32'd3);
    a_en = 1'b1; a_mode = 2'b11; a_data = 8'hA5;
    step(1);
    chk("prio_q", 32'(a_q), 32'hA5);

    a_load = 1'b0; a_mode = 2'b01; a_ser = 1'b1;
    step(2);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_q",    32'(a_q),    32'h0);
    chk("arst_ones", 32'(a_ones), 32'h0);
    chk("arst_an",   32'(a_an),   32'h2);
    chk("arst_seg",  32'(a_seg),  32'b1000000);
    chk("arst_bq",   32'(b_q),    32'h0);
    step(1);
    rst = 1'b1;
    step(3);
    chk("resume_q", 32'(a_q), 32'h07);
    a_mode = 2'b00;
    step(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pl_shift_reg_scan.md
PL_SHIFT_REG_SCAN -- requirements
Module: pl_shift_reg_scan

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, register width (legal 2..32).
REQ-002 The block SHALL have parameter SCAN_DIV, default 1000, clocks per display digit slot (legal >= 2).
REQ-003 The block SHALL define CW = clog2(WIDTH+1), the width of the ones count.
REQ-004 clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-low.
REQ-006 en  input  1  enable; low freezes q and ones.
REQ-007 load  input  1  parallel load request.
REQ-008 mode  input  2  operation: 00 hold, 01 shift left, 10 shift right, 11 rotate left (ring).
REQ-009 ser_in  input  1  serial input bit for the shift modes.
REQ-010 data  input  WIDTH  parallel load value.
REQ-011 q  output  WIDTH  register contents.
REQ-012 ones  output  CW  registered count of 1 bits in q.
REQ-013 seg  output  7  active-low segments {g,f,e,d,c,b,a}.
REQ-014 an  output  2  active-low digit enables; an[0] is units, an[1] is tens.

Function
REQ-015 Register priority on each edge SHALL be: en=0 hold; else load=1 q<=data; else apply mode.
REQ-016 Mode 01 SHALL set q<={q[WIDTH-2:0],ser_in}.
REQ-017 Mode 10 SHALL set q<={ser_in,q[WIDTH-1:1]}.
REQ-018 Mode 11 SHALL set q<={q[WIDTH-2:0],q[WIDTH-1]}; ser_in is ignored.
REQ-019 Mode 00 with load=0 SHALL hold q.
REQ-020 When en=1, ones SHALL take popcount(q) each edge, a latency of 1 cycle behind q; it is exact with no overflow, since CW holds WIDTH.
REQ-021 When en=0, ones SHALL hold.
REQ-022 A free-running scan counter SHALL count 0..SCAN_DIV-1 regardless of en, then wrap to 0.
REQ-023 The digit select SHALL toggle on the edge where the counter wraps.
REQ-024 When digit select is 0, an SHALL be 2'b10 and seg SHALL show ones mod 10.
REQ-025 When digit select is 1, an SHALL be 2'b01 and seg SHALL show ones div 10.
REQ-026 The tens digit SHALL be blanked (seg=7'b1111111) when ones < 10; an still toggles.
REQ-027 The digit encodings SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-028 seg and an SHALL be registered and change only on the edge after the digit select or ones changes.
REQ-029 Any unreachable digit value SHALL give seg=7'b1111111.

Reset
REQ-030 When rst=0, q, ones, the scan counter and the digit select SHALL clear to 0 immediately, without waiting for clk.
REQ-031 During reset, an SHALL be 2'b10 and seg 7'b1000000 (units digit shows "0").
REQ-032 A reset mid-shift or mid-scan SHALL abandon the operation; no partial state survives.
REQ-033 Operation SHALL resume on the first rising clk edge after rst returns high.

Verification
REQ-034 Load then count: WIDTH=8, en=1, load=1, data=8'hB5 -> q=8'hB5 next edge; ones=5 one edge later; units slot seg=0010010; tens slot seg=1111111.
REQ-035 Ring mode: after q=8'h01, mode=11 for 8 edges -> q walks 02,04,...,80,01; ones stays 1 throughout.
REQ-036 Shift with serial input: q=8'h00, mode=01, ser_in=1 for 3 edges -> q=8'h07, then ones=3; mode=10, ser_in=0 for 1 edge -> q=8'h03.
REQ-037 Enable and priority: en=0 with load=1 and data=8'hFF -> q and ones unchanged; en=1 with load=1 and mode=11 -> the load wins.
REQ-038 Two-digit display: WIDTH=16, SCAN_DIV=4, load 16'hFFFF -> ones=16; an alternates 10/01 every 4 clocks; seg = 0000010 ("6") in the units slot and 1111001 ("1") in the tens slot.
REQ-039 Async reset: assert rst=0 between edges while shifting -> q=0, ones=0, an=10, seg=1000000 before the next edge.
